// File: rtl/zeus_pkg.sv
// -----------------------------------------------------------------------------
// zeus_pkg -- shared definitions for the device-select timing logic.
//
// Contents:
//   DEV_*        device codes decoded by device_sel_timer (0 = no device)
//   fsm_state_t  access sequencer states (IDLE -> ACTIVE -> RECOVER -> IDLE)
//   cnt_width()  width needed for a down-counter that loads values 0..max_val
// -----------------------------------------------------------------------------
package zeus_pkg;

    localparam logic [3:0] DEV_NONE  = 4'd0;
    localparam logic [3:0] DEV_EXP   = 4'd1;
    localparam logic [3:0] DEV_AUDIO = 4'd2;
    localparam logic [3:0] DEV_VIDEO = 4'd3;
    localparam logic [3:0] DEV_IRQ   = 4'd4;
    localparam logic [3:0] DEV_SPI   = 4'd5;
    localparam logic [3:0] DEV_VIA   = 4'd6;
    localparam logic [3:0] DEV_SMC   = 4'd7;
    localparam logic [3:0] DEV_RAM   = 4'd8;
    localparam logic [3:0] DEV_VRAM  = 4'd9;
    localparam logic [3:0] DEV_MMU   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RECOVER = 2'd2
    } fsm_state_t;

    // A counter must hold at least one bit even when it only ever loads 0.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ws_counter.sv
// -----------------------------------------------------------------------------
// ws_counter -- loadable down-counter used for wait states and recovery time.
//
// Ports:
//   clk       block clock (rising edge)
//   reset_n   synchronous active-low reset, clears the count
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one; holds at zero
//   cnt       current count
//   zero      cnt == 0
// -----------------------------------------------------------------------------
module ws_counter
    import zeus_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d -- no latch.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/device_sel_timer.sv
// -----------------------------------------------------------------------------
// device_sel_timer -- decodes a device code into an active-low chip select and
// stretches the access by a per-device number of wait states, stalling the CPU
// meanwhile, then enforces a fixed recovery gap before the next access.
//
// Ports:
//   clk            block clock (rising edge)
//   reset_n        synchronous active-low reset
//   device_select  device code of the access being started (0 = none)
//   access_strobe  one-cycle pulse qualifying device_select
//   wait_cfg       wait states for device d in [d*WAIT_W +: WAIT_W]
//   dev_sel_n      registered active-low chip selects, at most one low
//   cpu_rdy        registered ready, low stalls the CPU
//   busy           high whenever an access or its recovery is in progress
//   collision      one-cycle pulse when a strobe arrives while busy (dropped)
//
// Timing for an access with W wait states accepted at edge T: the select is
// low for W+1 cycles from T+1, cpu_rdy is low for the first W of them, then
// RECOVER_CYCLES idle cycles follow before a new strobe can be accepted.
// -----------------------------------------------------------------------------
module device_sel_timer
    import zeus_pkg::*;
#(
    parameter int NUM_DEV        = 16,
    parameter int SEL_W          = 4,
    parameter int WAIT_W         = 3,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [SEL_W-1:0]          device_select,
    input  logic                      access_strobe,
    input  logic [NUM_DEV*WAIT_W-1:0] wait_cfg,
    output logic [NUM_DEV-1:0]        dev_sel_n,
    output logic                      cpu_rdy,
    output logic                      busy,
    output logic                      collision
);

    localparam int REC_W = cnt_width(RECOVER_CYCLES);

    fsm_state_t          state_q, state_d;
    logic [NUM_DEV-1:0]  dev_sel_n_q, dev_sel_n_d;
    logic                cpu_rdy_q, cpu_rdy_d;
    logic                collision_q, collision_d;

    logic                sel_valid;
    logic                accept;
    logic [WAIT_W-1:0]   wait_sel;
    logic [NUM_DEV-1:0]  sel_onehot_n;

    logic [WAIT_W-1:0]   wcnt;
    logic                wzero;
    logic [REC_W-1:0]    rcnt;
    logic                rzero;

    // Decode the incoming code; only meaningful on the accepting edge.
    always_comb begin
        sel_valid    = (device_select != '0) && (int'(device_select) < NUM_DEV);
        wait_sel     = '0;
        sel_onehot_n = '1;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (int'(device_select) == d) begin
                wait_sel        = wait_cfg[d*WAIT_W +: WAIT_W];
                sel_onehot_n[d] = 1'b0;
            end
        end
    end

    assign accept = access_strobe && sel_valid && (state_q == ST_IDLE);

    ws_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (wait_sel),
        .dec      (state_q == ST_ACTIVE),
        .cnt      (wcnt),
        .zero     (wzero)
    );

    // Loaded as the select is released, so it counts the RECOVER cycles.
    ws_counter #(.W(REC_W)) u_rec_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     ((state_q == ST_ACTIVE) && wzero),
        .load_val (REC_W'(RECOVER_CYCLES)),
        .dec      (state_q == ST_RECOVER),
        .cnt      (rcnt),
        .zero     (rzero)
    );

    always_comb begin
        state_d     = state_q;
        dev_sel_n_d = dev_sel_n_q;
        cpu_rdy_d   = cpu_rdy_q;
        // Any strobe outside IDLE is dropped and flagged.
        collision_d = access_strobe && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_ACTIVE;
                    dev_sel_n_d = sel_onehot_n;
                    cpu_rdy_d   = (wait_sel == '0);
                end
            end
            ST_ACTIVE: begin
                if (wzero) begin
                    dev_sel_n_d = '1;
                    state_d     = (RECOVER_CYCLES == 0) ? ST_IDLE : ST_RECOVER;
                end else if (wcnt == WAIT_W'(1)) begin
                    // Last wait state: release the CPU one cycle before the
                    // select so the data phase lines up with the final cycle.
                    cpu_rdy_d = 1'b1;
                end
            end
            ST_RECOVER: begin
                // Leave on the edge where the recovery count reaches zero.
                if (rzero || (rcnt == REC_W'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dev_sel_n_q <= '1;
            cpu_rdy_q   <= 1'b1;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dev_sel_n_q <= dev_sel_n_d;
            cpu_rdy_q   <= cpu_rdy_d;
            collision_q <= collision_d;
        end
    end

    assign dev_sel_n = dev_sel_n_q;
    assign cpu_rdy   = cpu_rdy_q;
    assign busy      = (state_q != ST_IDLE);
    assign collision = collision_q;

endmodule

// File: tb/tb_device_sel_timer.sv
// -----------------------------------------------------------------------------
// tb_device_sel_timer -- two instances (RECOVER_CYCLES = 1 and 2, NUM_DEV = 11)
// driven in parallel. A cycle-indexed model describes each access as time
// windows (select low, ready low, busy) and is compared every cycle; directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_device_sel_timer;

    localparam int NUM_DEV = 11;
    localparam int SEL_W   = 4;
    localparam int WAIT_W  = 3;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      access_strobe = 1'b0;
    logic [SEL_W-1:0]          device_select = '0;
    logic [NUM_DEV*WAIT_W-1:0] wait_cfg = '0;

    logic [NUM_DEV-1:0] sel_n_a, sel_n_b;
    logic               rdy_a, rdy_b, busy_a, busy_b, col_a, col_b;

    always #5 clk = ~clk;

    device_sel_timer #(
        .NUM_DEV(NUM_DEV), .SEL_W(SEL_W), .WAIT_W(WAIT_W), .RECOVER_CYCLES(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .device_select(device_select),
        .access_strobe(access_strobe), .wait_cfg(wait_cfg),
        .dev_sel_n(sel_n_a), .cpu_rdy(rdy_a), .busy(busy_a), .collision(col_a)
    );

    device_sel_timer #(
        .NUM_DEV(NUM_DEV), .SEL_W(SEL_W), .WAIT_W(WAIT_W), .RECOVER_CYCLES(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .device_select(device_select),
        .access_strobe(access_strobe), .wait_cfg(wait_cfg),
        .dev_sel_n(sel_n_b), .cpu_rdy(rdy_b), .busy(busy_b), .collision(col_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An accepted access starting at sample s with wait w: select low for
    // samples s..s+w, ready low for s..s+w-1, busy until s+w+1+R.
    typedef struct {
        bit has;
        int s;
        int w;
        int dev;
        int fin;
        bit col;
    } acc_t;

    acc_t m[2];
    int   rec[2] = '{1, 2};
    int   cyc = 0;
    bit   model_on = 1'b0;

    always @(posedge clk) begin : model
        int  old;
        bit  busy_old;
        bit  valid;
        old   = cyc;
        cyc   = cyc + 1;
        valid = (device_select != 0) && (int'(device_select) < NUM_DEV);
        for (int i = 0; i < 2; i++) begin
            busy_old = m[i].has && (old < m[i].fin);
            if (!reset_n) begin
                m[i].has = 1'b0;
                m[i].col = 1'b0;
            end else begin
                m[i].col = access_strobe && busy_old;
                if (access_strobe && !busy_old && valid) begin
                    m[i].has = 1'b1;
                    m[i].s   = cyc;
                    m[i].dev = int'(device_select);
                    m[i].w   = int'(wait_cfg[int'(device_select)*WAIT_W +: WAIT_W]);
                    m[i].fin = cyc + m[i].w + 1 + rec[i];
                end
            end
        end
    end

    function automatic logic [31:0] expected(input int i);
        logic [NUM_DEV-1:0] sel;
        logic               rdy;
        logic               bsy;
        sel = '1;
        rdy = 1'b1;
        bsy = 1'b0;
        if (m[i].has) begin
            if (cyc <= m[i].s + m[i].w) sel[m[i].dev] = 1'b0;
            if (cyc <  m[i].s + m[i].w) rdy = 1'b0;
            if (cyc <  m[i].fin)        bsy = 1'b1;
        end
        return 32'({sel, rdy, bsy, m[i].col});
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            check($sformatf("cycle%0d_a", cyc), 32'({sel_n_a, rdy_a, busy_a, col_a}), expected(0));
            check($sformatf("cycle%0d_b", cyc), 32'({sel_n_b, rdy_b, busy_b, col_b}), expected(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_wait(input int d, input int w);
        wait_cfg[d*WAIT_W +: WAIT_W] = WAIT_W'(w);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic strobe(input int code);
        device_select = SEL_W'(code);
        access_strobe = 1'b1;
        @(negedge clk);
        access_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples instance a for n negedges starting now. dev < 0: every low select
    // counts as "other". Optionally injects a strobe after sample inj_at.
    task automatic window(input int n, input int dev, input int inj_at, input int inj_dev,
                          output int sel_lo, output int rdy_lo, output int busy_hi,
                          output int col_hi, output int other_lo, output int first_rdy_lo);
        bit seen;
        sel_lo = 0; rdy_lo = 0; busy_hi = 0; col_hi = 0; other_lo = 0; first_rdy_lo = 0;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < NUM_DEV; d++) begin
                if (!sel_n_a[d]) begin
                    if (d == dev) sel_lo++;
                    else          other_lo++;
                end
            end
            if (dev >= 0 && !sel_n_a[dev] && !seen) begin
                seen = 1'b1;
                first_rdy_lo = int'(!rdy_a);
            end
            if (!rdy_a) rdy_lo++;
            if (busy_a) busy_hi++;
            if (col_a)  col_hi++;
            if (i == inj_at) begin
                device_select = SEL_W'(inj_dev);
                access_strobe = 1'b1;
            end else begin
                access_strobe = 1'b0;
            end
            @(negedge clk);
        end
        access_strobe = 1'b0;
    endtask

    int sl, rl, bh, ch, ol, fr;
    int codes[3] = '{0, 15, 11};
    bit lo1[9], lo2[9], bb[9], cb[9];

    initial begin : stim
        int last1, first2, overlap, gap_busy, col_cnt;

        // Reset
        reset_n = 1'b0;
        idle(3);
        model_on = 1'b1;
        check("reset_sel_n_a", 32'(sel_n_a), 32'(11'h7FF));
        check("reset_rdy_busy_col_a", 32'({rdy_a, busy_a, col_a}), 32'(3'b100));
        check("reset_sel_n_b", 32'(sel_n_b), 32'(11'h7FF));
        reset_n = 1'b1;
        idle(2);

        // VIA with zero wait states
        set_wait(6, 0);
        strobe(6);
        window(6, 6, -1, 0, sl, rl, bh, ch, ol, fr);
        check("via_sel_cycles", 32'(sl), 32'd1);
        check("via_rdy_low_cycles", 32'(rl), 32'd0);
        check("via_busy_cycles", 32'(bh), 32'd2);
        check("via_other_sel", 32'(ol), 32'd0);
        idle(2);

        // SMC with 3 wait states; inputs change mid-access and must be ignored
        set_wait(7, 3);
        strobe(7);
        set_wait(7, 7);
        device_select = SEL_W'(2);
        window(8, 7, -1, 0, sl, rl, bh, ch, ol, fr);
        check("smc_sel_cycles", 32'(sl), 32'd4);
        check("smc_rdy_low_cycles", 32'(rl), 32'd3);
        check("smc_rdy_low_first", 32'(fr), 32'd1);
        check("smc_other_sel", 32'(ol), 32'd0);
        check("smc_busy_cycles", 32'(bh), 32'd5);
        idle(2);

        // Codes that select nothing
        foreach (codes[k]) begin
            strobe(codes[k]);
            window(3, -1, -1, 0, sl, rl, bh, ch, ol, fr);
            check($sformatf("nodev%0d_sel", codes[k]), 32'(ol), 32'd0);
            check($sformatf("nodev%0d_rdy_busy_col", codes[k]), 32'({rl, bh, ch}), 32'd0);
        end

        // Collision: second strobe while a wait=5 access runs
        set_wait(3, 5);
        set_wait(5, 2);
        strobe(3);
        window(10, 3, 1, 5, sl, rl, bh, ch, ol, fr);
        check("col_pulses", 32'(ch), 32'd1);
        check("col_sel_cycles", 32'(sl), 32'd6);
        check("col_rdy_low_cycles", 32'(rl), 32'd5);
        check("col_other_sel", 32'(ol), 32'd0);
        idle(2);

        // Reset during cycle 2 of a wait=4 access, then reset with a strobe
        set_wait(4, 4);
        strobe(4);
        idle(1);
        reset_n = 1'b0;
        idle(1);
        check("rst_mid_sel_n", 32'(sel_n_a), 32'(11'h7FF));
        check("rst_mid_rdy_busy", 32'({rdy_a, busy_a}), 32'(2'b10));
        strobe(1);
        check("rst_strobe_sel_n", 32'(sel_n_a), 32'(11'h7FF));
        check("rst_strobe_busy", 32'(busy_a), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Back-to-back EXP then AUDIO on the RECOVER_CYCLES=2 instance
        set_wait(1, 1);
        set_wait(2, 1);
        strobe(1);
        for (int i = 0; i < 9; i++) begin
            lo1[i] = !sel_n_b[1];
            lo2[i] = !sel_n_b[2];
            bb[i]  = busy_b;
            cb[i]  = col_b;
            if (i == 4) begin
                device_select = SEL_W'(2);
                access_strobe = 1'b1;
            end else begin
                access_strobe = 1'b0;
            end
            @(negedge clk);
        end
        access_strobe = 1'b0;
        last1 = -1; first2 = -1; overlap = 0; col_cnt = 0; gap_busy = 0;
        for (int i = 0; i < 9; i++) begin
            if (lo1[i]) last1 = i;
            if (lo2[i] && first2 < 0) first2 = i;
            if (lo1[i] && lo2[i]) overlap++;
            if (cb[i]) col_cnt++;
        end
        for (int i = 0; i < 9; i++) begin
            if (i > last1 && i < first2 && bb[i] && !lo1[i] && !lo2[i]) gap_busy++;
        end
        check("b2b_overlap", 32'(overlap), 32'd0);
        check("b2b_last_exp", 32'(last1), 32'd1);
        check("b2b_first_audio", 32'(first2), 32'd5);
        check("b2b_recover_gap", 32'(gap_busy), 32'd2);
        check("b2b_collisions", 32'(col_cnt), 32'd0);
        idle(6);

        model_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/device_sel_timer.md
DEVICE_SEL_TIMER -- requirements
Module: device_sel_timer

Interface
REQ-001 Parameter NUM_DEV, default 16: number of decoded device-select outputs; code 0 means "no device".
REQ-002 Parameter SEL_W, default 4: width of device_select; NUM_DEV SHALL be ≤ 2**SEL_W.
REQ-003 Parameter WAIT_W, default 3: width of each per-device wait-state field.
REQ-004 Parameter RECOVER_CYCLES, default 1: idle cycles enforced after each access (0 allowed).
REQ-005 Port clk, input, 1: the single block clock; all logic on its rising edge.
REQ-006 Port reset_n, input, 1: synchronous, active-low reset.
REQ-007 Port device_select, input, SEL_W: device code for the access being started.
REQ-008 Port access_strobe, input, 1: one-cycle pulse marking a valid device_select.
REQ-009 Port wait_cfg, input, NUM_DEV*WAIT_W: wait states for device d in bits [d*WAIT_W +: WAIT_W].
REQ-010 Port dev_sel_n, output, NUM_DEV: registered active-low chip selects; at most one bit low.
REQ-011 Port cpu_rdy, output, 1: registered; low stalls the CPU.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Port collision, output, 1: one-cycle pulse when a strobe is dropped.

Function
REQ-014 FSM states SHALL be IDLE, ACTIVE and RECOVER.
REQ-015 IDLE + access_strobe + 0 < device_select < NUM_DEV at edge T: next state ACTIVE; dev_sel_n[device_select] low from T+1; cnt loaded with W = wait_cfg field; cpu_rdy = (W == 0).
REQ-016 IDLE + strobe with device_select == 0 or ≥ NUM_DEV: no select asserted, cpu_rdy stays high, state stays IDLE, no collision.
REQ-017 ACTIVE with cnt > 1: cnt decrements; cpu_rdy stays low.
REQ-018 ACTIVE with cnt == 1: cnt becomes 0; cpu_rdy goes high.
REQ-019 ACTIVE with cnt == 0: dev_sel_n returns all-high; next state RECOVER with the recovery counter loaded with RECOVER_CYCLES, or IDLE if RECOVER_CYCLES == 0.
REQ-020 Net timing: the select is low for exactly W+1 cycles, and cpu_rdy is low for exactly W cycles beginning with the select's first cycle.
REQ-021 RECOVER: the counter decrements each cycle and the state returns to IDLE on the cycle it reaches 0; all selects stay high.
REQ-022 A strobe in ACTIVE or RECOVER SHALL be ignored and SHALL pulse collision high for one cycle.
REQ-023 wait_cfg and device_select are sampled only at the accepting edge; changes mid-access have no effect.
REQ-024 An accepting strobe is possible on the first IDLE cycle after RECOVER (back-to-back throughput = W + 2 + RECOVER_CYCLES cycles).

Reset
REQ-025 reset_n low at a rising edge: state IDLE, dev_sel_n all-high, cpu_rdy high, busy low, collision low, counters zero.
REQ-026 Reset SHALL take priority over any in-progress access and over a simultaneous strobe.

Structure
REQ-027 Device codes (EXP=1, AUDIO=2, VIDEO=3, IRQ=4, SPI=5, VIA=6, SMC=7, RAM=8, VRAM=9, MMU=10) and the FSM state enum SHALL live in shared package zeus_pkg.
REQ-028 The wait/recovery down-counter SHALL be one sub-module, ws_counter (load, decrement, zero flag), instantiated twice.

Verification
REQ-029 VIA (6) strobe with wait_cfg[6] = 0: dev_sel_n[6] low for 1 cycle; cpu_rdy never low; busy high for 2 cycles.
REQ-030 SMC (7) with wait = 3: dev_sel_n[7] low for 4 cycles; cpu_rdy low for 3 cycles, starting with the select's first cycle.
REQ-031 Strobe with codes 0 and 15 (NUM_DEV = 11): no select asserted, cpu_rdy high, busy low.
REQ-032 Second strobe 2 cycles into a wait = 5 access: collision pulses once; the original access completes unchanged.
REQ-033 reset_n low during cycle 2 of a wait = 4 access: on the next edge all selects high, cpu_rdy high, state IDLE.
REQ-034 Back-to-back EXP/AUDIO accesses with wait = 1 and RECOVER_CYCLES = 2: selects never overlap, with a gap of 2 cycles between them.
